// File: rtl/people_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : people_motion_ctrl
//  Description : Movement sequencer for the player sprite. A free-running
//                counter produces a movement tick; on each tick while walking
//                the sprite box steps by STEP pixels per active axis, clamped
//                to the screen. Tracks facing direction and a 2-bit walk
//                animation frame for the sprite ROM image select.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                key_up/down_k/left/right - held WASD key levels (clk domain)
//                freeze                - suspends movement (pause)
//                people_*_border       - registered sprite box corners
//                dir                   - facing, 0 = left, 1 = right
//                frame                 - walk animation frame 0..3
//                moving                - registered "state is WALK" decode
//                tick                  - one-cycle movement tick pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module people_motion_ctrl #(
   parameter int X_INIT     = 320,
   parameter int Y_INIT     = 240,
   parameter int W          = 40,
   parameter int H          = 40,
   parameter int STEP       = 2,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479,
   parameter int TICK_DIV   = 1_000_000,
   parameter int ANIM_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_down_k,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       freeze,
   output logic [9:0] people_left_border,
   output logic [9:0] people_up_border,
   output logic [9:0] people_right_border,
   output logic [9:0] people_down_border,
   output logic       dir,
   output logic [1:0] frame,
   output logic       moving,
   output logic       tick
);

   localparam int c_TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int c_ACW = $clog2(ANIM_TICKS + 1);

   localparam logic [c_TCW-1:0] c_TICK_LAST = c_TCW'(TICK_DIV - 1);
   localparam logic [c_TCW-1:0] c_TICK_PRE  = c_TCW'(TICK_DIV - 2);
   localparam logic [c_ACW-1:0] c_ANIM_LAST = c_ACW'(ANIM_TICKS - 1);

   // 11-bit working width so that +STEP near the bottom/right edge cannot wrap
   localparam logic [10:0] c_STEP = 11'(STEP);
   localparam logic [10:0] c_X_HI = 11'(X_MAX - W + 1);  // largest legal left
   localparam logic [10:0] c_Y_HI = 11'(Y_MAX - H + 1);  // largest legal up
   localparam logic [10:0] c_W_M1 = 11'(W - 1);
   localparam logic [10:0] c_H_M1 = 11'(H - 1);

   localparam logic [9:0] c_X_INIT   = 10'(X_INIT);
   localparam logic [9:0] c_Y_INIT   = 10'(Y_INIT);
   localparam logic [9:0] c_X_INIT_R = 10'(X_INIT + W - 1);
   localparam logic [9:0] c_Y_INIT_D = 10'(Y_INIT + H - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WALK   = 2'd1,
      S_FROZEN = 2'd2
   } state_t;

   state_t           r_state;
   logic [c_TCW-1:0] r_tick_cnt;
   logic [c_ACW-1:0] r_anim_cnt;
   logic             r_tick;
   logic             r_moving;
   logic             r_dir;
   logic [1:0]       r_frame;
   logic [9:0]       r_left;
   logic [9:0]       r_up;
   logic [9:0]       r_right;
   logic [9:0]       r_down;

   logic             w_h;
   logic             w_v;
   logic             w_any;
   logic [10:0]      w_left_ext;
   logic [10:0]      w_up_ext;
   logic [9:0]       w_left_nxt;
   logic [9:0]       w_up_nxt;

   // Opposite keys held together cancel out on that axis
   assign w_h        = key_left ^ key_right;
   assign w_v        = key_up ^ key_down_k;
   assign w_any      = w_h | w_v;
   assign w_left_ext = {1'b0, r_left};
   assign w_up_ext   = {1'b0, r_up};

   // Candidate top-left corner for a walk tick, clamped to the screen
   always_comb begin
      w_left_nxt = r_left;
      w_up_nxt   = r_up;
      if (w_h) begin
         if (key_left)
            w_left_nxt = (w_left_ext >= c_STEP) ? 10'(w_left_ext - c_STEP) : '0;
         else
            w_left_nxt = (w_left_ext + c_STEP <= c_X_HI) ? 10'(w_left_ext + c_STEP)
                                                        : 10'(c_X_HI);
      end
      if (w_v) begin
         if (key_up)
            w_up_nxt = (w_up_ext >= c_STEP) ? 10'(w_up_ext - c_STEP) : '0;
         else
            w_up_nxt = (w_up_ext + c_STEP <= c_Y_HI) ? 10'(w_up_ext + c_STEP)
                                                    : 10'(c_Y_HI);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
         r_anim_cnt <= '0;
         r_moving   <= 1'b0;
         r_dir      <= 1'b0;
         r_frame    <= 2'd0;
         r_left     <= c_X_INIT;
         r_up       <= c_Y_INIT;
         r_right    <= c_X_INIT_R;
         r_down     <= c_Y_INIT_D;
      end else begin
         r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
         // Registered pulse, aligned with the cycle where the count is last
         r_tick     <= (r_tick_cnt == c_TICK_PRE);
         r_moving   <= (r_state == S_WALK);

         if (freeze) begin
            // Freeze wins, including over a tick in this same cycle
            r_state <= S_FROZEN;
         end else begin
            case (r_state)
               S_FROZEN: begin
                  r_state    <= S_IDLE;
                  r_anim_cnt <= '0;
                  r_frame    <= 2'd0;
               end
               S_IDLE: begin
                  if (w_any)
                     r_state <= S_WALK;
               end
               S_WALK: begin
                  if (!w_any) begin
                     r_state    <= S_IDLE;
                     r_anim_cnt <= '0;
                     r_frame    <= 2'd0;
                  end else if (r_tick) begin
                     r_left  <= w_left_nxt;
                     r_up    <= w_up_nxt;
                     r_right <= 10'({1'b0, w_left_nxt} + c_W_M1);
                     r_down  <= 10'({1'b0, w_up_nxt} + c_H_M1);
                     if (w_h)
                        r_dir <= key_right;
                     // Animation advances even when clamping leaves the box still
                     if (r_anim_cnt == c_ANIM_LAST) begin
                        r_anim_cnt <= '0;
                        r_frame    <= r_frame + 2'd1;
                     end else begin
                        r_anim_cnt <= r_anim_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign people_left_border  = r_left;
   assign people_up_border    = r_up;
   assign people_right_border = r_right;
   assign people_down_border  = r_down;
   assign dir                 = r_dir;
   assign frame               = r_frame;
   assign moving              = r_moving;
   assign tick                = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_people_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_people_motion_ctrl
//  Description : Self-checking bench for people_motion_ctrl with a fast tick
//                (TICK_DIV=4, ANIM_TICKS=2). Directed scenarios plus a random
//                key/freeze/reset run against a behavioural screen model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_people_motion_ctrl;

   localparam int TD = 4;
   localparam int AT = 2;
   localparam int XI = 320;
   localparam int YI = 240;
   localparam int WW = 40;
   localparam int HH = 40;
   localparam int ST = 2;
   localparam int XM = 639;
   localparam int YM = 479;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_up = 1'b0;
   logic       key_down_k = 1'b0;
   logic       key_left = 1'b0;
   logic       key_right = 1'b0;
   logic       freeze = 1'b0;
   logic [9:0] people_left_border;
   logic [9:0] people_up_border;
   logic [9:0] people_right_border;
   logic [9:0] people_down_border;
   logic       dir;
   logic [1:0] frame;
   logic       moving;
   logic       tick;

   int checks = 0;
   int errors = 0;

   // Behavioural model: positions as plain integers, mode 0=idle 1=walk 2=frozen
   int m_left, m_up, m_dir, m_frame, m_anim, m_mode, m_moving, m_cnt, m_tick;

   people_motion_ctrl #(
      .X_INIT(XI), .Y_INIT(YI), .W(WW), .H(HH), .STEP(ST),
      .X_MAX(XM), .Y_MAX(YM), .TICK_DIV(TD), .ANIM_TICKS(AT)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .key_up              (key_up),
      .key_down_k          (key_down_k),
      .key_left            (key_left),
      .key_right           (key_right),
      .freeze              (freeze),
      .people_left_border  (people_left_border),
      .people_up_border    (people_up_border),
      .people_right_border (people_right_border),
      .people_down_border  (people_down_border),
      .dir                 (dir),
      .frame               (frame),
      .moving              (moving),
      .tick                (tick)
   );

   always #5 clk = ~clk;

   function automatic int clampi(input int val, input int lo, input int hi);
      return (val < lo) ? lo : ((val > hi) ? hi : val);
   endfunction

   task automatic model_edge();
      int  h, v;
      bit  was_tick;
      if (rst) begin
         m_left = XI; m_up = YI; m_dir = 0; m_frame = 0; m_anim = 0;
         m_mode = 0; m_moving = 0; m_cnt = 0;
      end else begin
         h = (key_left != key_right) ? (key_right ? 1 : -1) : 0;
         v = (key_up != key_down_k) ? (key_down_k ? 1 : -1) : 0;
         was_tick = (m_cnt == TD - 1);
         m_moving = (m_mode == 1) ? 1 : 0;
         if (freeze) begin
            m_mode = 2;
         end else if (m_mode == 2 || (h == 0 && v == 0)) begin
            m_mode = 0; m_anim = 0; m_frame = 0;
         end else begin
            if (m_mode == 1 && was_tick) begin
               m_left = clampi(m_left + h * ST, 0, XM - WW + 1);
               m_up   = clampi(m_up + v * ST, 0, YM - HH + 1);
               if (h != 0) m_dir = (h > 0) ? 1 : 0;
               m_anim = m_anim + 1;
               if (m_anim == AT) begin
                  m_anim  = 0;
                  m_frame = (m_frame + 1) % 4;
               end
            end
            m_mode = 1;
         end
         m_cnt = (m_cnt + 1) % TD;
      end
      m_tick = (m_cnt == TD - 1) ? 1 : 0;
   endtask

   // One clock: model follows the edge, return at the following negedge
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic wait_tick();
      int n = 0;
      while (tick !== 1'b1 && n < 3 * TD) begin
         cycle();
         n++;
      end
      checks++;
      if (tick !== 1'b1) begin
         errors++;
         $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
      end
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         wait_tick();
         cycle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cycle();
      checks++;
      if (people_left_border !== 10'd320) begin
         errors++; $display("FAIL reset_left: got %0d required 320", people_left_border);
      end
      checks++;
      if (people_up_border !== 10'd240) begin
         errors++; $display("FAIL reset_up: got %0d required 240", people_up_border);
      end
      checks++;
      if (people_right_border !== 10'd359 || people_down_border !== 10'd279) begin
         errors++; $display("FAIL reset_rd: got %0d/%0d required 359/279",
                            people_right_border, people_down_border);
      end
      checks++;
      if ({dir, frame, moving, tick} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: dir=%b frame=%0d moving=%b tick=%b required all 0",
                            dir, frame, moving, tick);
      end
      rst = 1'b0;
      // Counting the current post-reset cycle as the first, tick is the fourth
      for (int i = 1; i < TD; i++) begin
         cycle();
         checks++;
         if (tick !== ((i == TD - 1) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL first_tick: cycle %0d tick=%b required %b",
                               i, tick, (i == TD - 1));
         end
      end
   endtask

   task automatic test_walk_right();
      key_right = 1'b1;
      cycle();
      for (int k = 0; k < 3; k++) begin
         wait_tick();
         checks++;
         if (people_left_border !== 10'(320 + 2 * k)) begin
            errors++; $display("FAIL walk_pre_tick%0d: left=%0d required %0d",
                               k, people_left_border, 320 + 2 * k);
         end
         cycle();
         checks++;
         if (people_left_border !== 10'(322 + 2 * k) || people_right_border !== 10'(361 + 2 * k)) begin
            errors++; $display("FAIL walk_tick%0d: left/right=%0d/%0d required %0d/%0d",
                               k, people_left_border, people_right_border, 322 + 2 * k, 361 + 2 * k);
         end
         checks++;
         if (dir !== 1'b1 || frame !== ((k >= 1) ? 2'd1 : 2'd0) || moving !== 1'b1) begin
            errors++; $display("FAIL walk_flags%0d: dir=%b frame=%0d moving=%b required 1/%0d/1",
                               k, dir, frame, moving, (k >= 1));
         end
      end
   endtask

   task automatic test_right_clamp();
      int f0;
      run_ticks(140);
      checks++;
      if (people_left_border !== 10'd600 || people_right_border !== 10'd639) begin
         errors++; $display("FAIL rclamp: left/right=%0d/%0d required 600/639",
                            people_left_border, people_right_border);
      end
      f0 = m_frame;
      run_ticks(4);
      checks++;
      if (people_left_border !== 10'd600 || frame !== 2'((f0 + 2) % 4)) begin
         errors++; $display("FAIL rclamp_hold: left=%0d frame=%0d required 600/%0d",
                            people_left_border, frame, (f0 + 2) % 4);
      end
   endtask

   task automatic test_top_clamp();
      key_right = 1'b0;
      key_up    = 1'b1;
      run_ticks(125);
      checks++;
      if (people_up_border !== 10'd0 || people_down_border !== 10'd39 || people_left_border !== 10'd600) begin
         errors++; $display("FAIL tclamp: up/down/left=%0d/%0d/%0d required 0/39/600",
                            people_up_border, people_down_border, people_left_border);
      end
      run_ticks(2);
      checks++;
      if (people_up_border !== 10'd0) begin
         errors++; $display("FAIL tclamp_hold: up=%0d required 0", people_up_border);
      end
   endtask

   task automatic test_opposite();
      key_up = 1'b0; key_left = 1'b1; key_right = 1'b1; key_down_k = 1'b1;
      run_ticks(3);
      checks++;
      if (people_up_border !== 10'd6 || people_down_border !== 10'd45) begin
         errors++; $display("FAIL opp_up: up/down=%0d/%0d required 6/45",
                            people_up_border, people_down_border);
      end
      checks++;
      if (people_left_border !== 10'd600 || dir !== 1'b1) begin
         errors++; $display("FAIL opp_h: left=%0d dir=%b required 600/1", people_left_border, dir);
      end
   endtask

   task automatic test_freeze();
      int f0;
      key_right = 1'b0; key_down_k = 1'b0; key_left = 1'b1;
      cycle();
      wait_tick();
      f0 = m_frame;
      freeze = 1'b1;
      cycle();
      checks++;
      if (people_left_border !== 10'd600 || frame !== 2'(f0)) begin
         errors++; $display("FAIL freeze_tick: left=%0d frame=%0d required 600/%0d",
                            people_left_border, frame, f0);
      end
      repeat (6) cycle();
      checks++;
      if (people_left_border !== 10'd600 || frame !== 2'(f0) || moving !== 1'b0) begin
         errors++; $display("FAIL frozen_hold: left=%0d frame=%0d moving=%b required 600/%0d/0",
                            people_left_border, frame, moving, f0);
      end
      freeze = 1'b0;
      cycle();
      checks++;
      if (frame !== 2'd0) begin
         errors++; $display("FAIL unfreeze_idle: frame=%0d required 0", frame);
      end
      repeat (2) cycle();
      checks++;
      if (moving !== 1'b1) begin
         errors++; $display("FAIL unfreeze_walk: moving=%b required 1", moving);
      end
   endtask

   task automatic test_reset_mid();
      run_ticks(2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (people_left_border !== 10'd320 || people_up_border !== 10'd240 ||
          people_right_border !== 10'd359 || people_down_border !== 10'd279 ||
          {dir, frame, moving, tick} !== 5'b0) begin
         errors++; $display("FAIL reset_mid: l/u/r/d=%0d/%0d/%0d/%0d dir=%b frame=%0d mv=%b tk=%b required 320/240/359/279 zeros",
                            people_left_border, people_up_border, people_right_border,
                            people_down_border, dir, frame, moving, tick);
      end
   endtask

   task automatic test_random();
      logic [44:0] act, exp;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            {key_up, key_down_k, key_left, key_right} = 4'($urandom);
         freeze = ($urandom_range(0, 39) == 0);
         rst    = ($urandom_range(0, 999) == 0);
         cycle();
         act = {people_left_border, people_up_border, people_right_border,
                people_down_border, dir, frame, moving, tick};
         exp = {10'(m_left), 10'(m_up), 10'(m_left + WW - 1), 10'(m_up + HH - 1),
                1'(m_dir), 2'(m_frame), 1'(m_moving), 1'(m_tick)};
         checks++;
         if (act !== exp) begin
            errors++; $display("FAIL random_cycle%0d: got %h required %h", i, act, exp);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_walk_right();
      test_right_clamp();
      test_top_clamp();
      test_opposite();
      test_freeze();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/people_motion_ctrl.md
# people_motion_ctrl

Movement sequencer for the player sprite. Paces position updates from held WASD key levels with a free-running movement tick, clamps the sprite box to the screen, tracks facing direction and generates a walk-animation frame index. Its border and direction outputs feed the sprite pixel/address datapath, which reads `dir` and `frame` to select the sprite ROM image.

## Interface
Parameters:
- `X_INIT`, 320, reset left border
- `Y_INIT`, 240, reset up border
- `W`, 40, sprite width in pixels
- `H`, 40, sprite height in pixels
- `STEP`, 2, pixels moved per tick per axis
- `X_MAX`, 639, last legal screen column; minimum column is 0
- `Y_MAX`, 479, last legal screen row; minimum row is 0
- `TICK_DIV`, 1_000_000, clk cycles per movement tick (≥2)
- `ANIM_TICKS`, 8, movement ticks per animation frame (≥1)

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `key_up`, `key_down_k`, `key_left`, `key_right` in 1 each: held-key levels for w/s/a/d, already synchronous to `clk`.
- `freeze` in 1: suspends movement, for example while the game is paused.
- `people_left_border`, `people_up_border` out 10: registered top-left corner.
- `people_right_border`, `people_down_border` out 10: registered, always left+W−1 and up+H−1.
- `dir` out 1: 0 = LEFT, 1 = RIGHT.
- `frame` out 2: walk-animation frame, 0..3.
- `moving` out 1: high while in WALK.
- `tick` out 1: one-cycle movement tick pulse.

## Operation
- **Tick counter:**
  - `tick_cnt` counts 0..TICK_DIV−1 and wraps.
  - `tick` is high in the cycle where `tick_cnt` == TICK_DIV−1.
  - The counter runs regardless of state and `freeze`.
- **Per-axis intent:**
  - `h` = left XOR right; `v` = up XOR down.
  - When both opposite keys are held, that axis is idle.
  - `any` = `h` | `v`.
- **FSM states:** IDLE, WALK, FROZEN.
  - Any state → FROZEN when `freeze`=1 (highest priority).
  - FROZEN → IDLE when `freeze`=0.
  - IDLE → WALK when `any`=1.
  - WALK → IDLE when `any`=0.
  - State transitions happen on any clock edge, not only on ticks.
- **Position update:** only when state==WALK and `tick`=1 in the same cycle. Arithmetic is 11-bit unsigned to avoid wrap.
  - Left: new_left = (left ≥ STEP) ? left−STEP : 0.
  - Right: new_left = (left+W−1+STEP ≤ X_MAX) ? left+STEP : X_MAX−W+1.
  - Up/down use the same rules with `up`, H and Y_MAX.
  - Both axes may update in the same tick (diagonal).
- **Direction:**
  - `dir` ← LEFT on a tick where `h` is active and left is held.
  - `dir` ← RIGHT on a tick where `h` is active and right is held.
  - Otherwise `dir` is unchanged, including when left and right are held together, and in IDLE and FROZEN.
- **Animation:**
  - `anim_cnt` (0..ANIM_TICKS−1) advances on each WALK tick.
  - On wrap, `frame` increments mod 4.
  - Entering IDLE clears `anim_cnt` and `frame` to 0.
  - FROZEN holds both.
- **Clamped ticks:** a tick where clamping yields no position change on every active axis still advances the animation.

## Timing
- **Reset values** (applied on `rst` at a clock edge):
  - `people_left_border`=X_INIT, `people_up_border`=Y_INIT.
  - `people_right_border`=X_INIT+W−1, `people_down_border`=Y_INIT+H−1.
  - `dir`=0, `frame`=0, `moving`=0, `tick`=0.
  - `tick_cnt`=0, `anim_cnt`=0, state=IDLE.
- **Reset mid-operation:** `rst` overrides everything at the edge it is sampled; `tick_cnt` restarts at 0, so the first tick comes TICK_DIV cycles after reset deasserts.
- **Key-to-state latency:**
  - Keys sampled at edge E move state to WALK at E.
  - `moving` is a registered decode and is visible one cycle after the state register changes.
- **Position latency:**
  - Uses the keys and state present in the `tick` cycle.
  - All four borders, `dir` and `frame` change together at the end of that cycle, i.e. visible the cycle after `tick`.
  - Right and down borders never lag the left and up borders.
- **Simultaneous events:**
  - When `freeze` rises in a `tick` cycle, that tick's update is suppressed.
  - When keys release in the `tick` cycle, no update occurs.

## Test plan
Benches run with TICK_DIV=4, ANIM_TICKS=2.
- **Reset:** hold `rst` for 3 cycles → borders 320/240/359/279, `dir`=0, `frame`=0, first `tick` exactly 4 cycles after release.
- **Hold right for 3 ticks** → left borders 322, 324, 326, each visible one cycle after `tick`; `dir`=1; `frame` goes 0→1 after the 2nd tick.
- **Right-edge clamp:** start at left=598 (preloaded via X_INIT=598) and hold right → 600, then 600 on following ticks; right border stays 639; `frame` keeps advancing.
- **Top-edge clamp:** with Y_INIT=1, hold up → up border 0 and stays 0; no wrap to 1023.
- **Opposite keys:** hold left+right+down → only the up border changes (+2 per tick) and `dir` is unchanged.
- **Freeze and reset mid-walk:**
  - Assert `freeze` mid-walk in a tick cycle → no position change; `frame` held.
  - Release → IDLE, or WALK if keys are still held.
  - Assert `rst` mid-walk → reset values on the next cycle.
